// File: rtl/exec_stage_pipe_if.sv
// exec_stage_pipe_if: D/E operands, hazard controls and E/M outputs
// of the PIPE Y86-64 execute stage, bundled for one port.
interface exec_stage_pipe_if #(
    parameter int unsigned WIDTH = 64
);
    logic [2:0]       e_stat;
    logic [3:0]       e_icode;
    logic [3:0]       e_ifun;
    logic [WIDTH-1:0] e_valA;
    logic [WIDTH-1:0] e_valB;
    logic [WIDTH-1:0] e_valC;
    logic [3:0]       e_dstE_in;
    logic [3:0]       e_dstM;
    logic             set_cc_block;
    logic             m_stall;
    logic             m_bubble;
    logic [WIDTH-1:0] e_valE;
    logic [3:0]       e_dstE;
    logic             e_cnd;
    logic [2:0]       cc_out;
    logic             busy;
    logic [2:0]       M_stat;
    logic [3:0]       M_icode;
    logic             M_cnd;
    logic [WIDTH-1:0] M_valE;
    logic [WIDTH-1:0] M_valA;
    logic [3:0]       M_dstE;
    logic [3:0]       M_dstM;

    modport master (
        output e_stat, e_icode, e_ifun, e_valA, e_valB, e_valC,
        output e_dstE_in, e_dstM, set_cc_block, m_stall, m_bubble,
        input  e_valE, e_dstE, e_cnd, cc_out, busy,
        input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  e_stat, e_icode, e_ifun, e_valA, e_valB, e_valC,
        input  e_dstE_in, e_dstM, set_cc_block, m_stall, m_bubble,
        output e_valE, e_dstE, e_cnd, cc_out, busy,
        output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/exec_stage_pipe.sv
// exec_stage_pipe: PIPE Y86-64 execute stage, CC register and E/M register.
// Define EXEC_MUL_EN to add an iterative shift-add mulq (OPq ifun 4).
module exec_stage_pipe #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned STACK_STEP = 8,
    parameter logic [3:0]  RNONE      = 4'hF
) (
    input logic               clk,
    input logic               rst,
    exec_stage_pipe_if.slave  io
);
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [2:0] S_AOK   = 3'd1;
    localparam logic [2:0] S_INS   = 3'd4;
    localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

    typedef struct packed {
        logic [2:0]       stat;
        logic [3:0]       icode;
        logic             cnd;
        logic [WIDTH-1:0] valE;
        logic [WIDTH-1:0] valA;
        logic [3:0]       dstE;
        logic [3:0]       dstM;
    } em_t;

    localparam em_t EM_BUBBLE = '{stat: S_AOK, icode: I_NOP, cnd: 1'b0,
                                  valE: '0, valA: '0,
                                  dstE: RNONE, dstM: RNONE};

    logic [WIDTH-1:0] a, b, c;
    logic             is_op, op_ok, cc_we, mul_hold, cond;
    logic [WIDTH-1:0] alu_res, vale;
    logic             alu_of;
    logic [2:0]       cc_q, cc_d;
    em_t              em_q, em_d;

    assign a     = io.e_valA;
    assign b     = io.e_valB;
    assign c     = io.e_valC;
    assign is_op = (io.e_icode == I_OPQ);

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} mstate_e;
    localparam int unsigned CW = $clog2(WIDTH);

    mstate_e          st_q, st_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
    logic             mul_start, mul_done;

    assign mul_start = is_op && io.e_ifun == 4'h4 && io.e_stat == S_AOK;
    assign mul_done  = (st_q == DONE);
    assign mul_hold  = mul_start && !mul_done;
    assign op_ok     = (io.e_ifun <= 4'h4);
    assign io.busy   = (st_q == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        unique case (st_q)
            IDLE: if (mul_start) begin
                st_d     = RUN;
                cnt_d    = '0;
                mcand_d  = b;
                mplier_d = a;
                prod_d   = '0;
            end
            RUN: begin
                if (mplier_q[0]) prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) st_d = DONE;
            end
            DONE: if (!io.m_stall) st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end
`else
    assign mul_hold = 1'b0;
    assign op_ok    = (io.e_ifun <= 4'h3);
    assign io.busy  = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        unique case (io.e_ifun)
            4'h0: begin
                alu_res = b + a;
                alu_of  = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != b[WIDTH-1]);
            end
            4'h1: begin
                alu_res = b - a;
                alu_of  = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != b[WIDTH-1]);
            end
            4'h2: alu_res = b & a;
            4'h3: alu_res = b ^ a;
`ifdef EXEC_MUL_EN
            4'h4: alu_res = mul_done ? prod_q : '0;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        vale = '0;
        unique case (io.e_icode)
            I_IRMOV:         vale = c;
            I_RMMOV, I_MRMOV: vale = b + c;
            I_RRMOV:         vale = a;
            I_OPQ:           vale = op_ok ? alu_res : '0;
            I_CALL, I_PUSH:  vale = b - STEP;
            I_RET, I_POP:    vale = b + STEP;
            default:         vale = '0;
        endcase
    end

    // Conditions read the registered flags, never the in-flight OPq.
    always_comb begin
        cond = 1'b0;
        unique case (io.e_ifun)
            4'h0: cond = 1'b1;
            4'h1: cond = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'h2: cond = cc_q[1] ^ cc_q[0];
            4'h3: cond = cc_q[2];
            4'h4: cond = ~cc_q[2];
            4'h5: cond = ~(cc_q[1] ^ cc_q[0]);
            4'h6: cond = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
            default: cond = 1'b0;
        endcase
    end

    assign io.e_cnd  = (io.e_icode == I_RRMOV || io.e_icode == I_JXX) && cond;
    assign io.e_dstE = (io.e_icode == I_RRMOV && !io.e_cnd) ? RNONE
                                                             : io.e_dstE_in;
    assign io.e_valE = vale;

    assign cc_we = is_op && op_ok && !io.set_cc_block &&
                   io.e_stat == S_AOK && !io.m_stall && !mul_hold;
    assign cc_d  = cc_we ? {alu_res == '0, alu_res[WIDTH-1], alu_of} : cc_q;

    always_comb begin
        em_d = em_q;
        if (io.m_stall) begin
            em_d = em_q;
        end else if (io.m_bubble || mul_hold) begin
            em_d = EM_BUBBLE;
        end else begin
            em_d.stat  = (is_op && !op_ok) ? S_INS : io.e_stat;
            em_d.icode = io.e_icode;
            em_d.cnd   = io.e_cnd;
            em_d.valE  = vale;
            em_d.valA  = a;
            em_d.dstE  = io.e_dstE;
            em_d.dstM  = io.e_dstM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= 3'b100;
            em_q <= EM_BUBBLE;
        end else begin
            cc_q <= cc_d;
            em_q <= em_d;
        end
    end

    assign io.cc_out  = cc_q;
    assign io.M_stat  = em_q.stat;
    assign io.M_icode = em_q.icode;
    assign io.M_cnd   = em_q.cnd;
    assign io.M_valE  = em_q.valE;
    assign io.M_valA  = em_q.valA;
    assign io.M_dstE  = em_q.dstE;
    assign io.M_dstM  = em_q.dstM;
endmodule

// File: tb/tb_exec_stage_pipe.sv
// tb_exec_stage_pipe: directed plus randomized checks of exec_stage_pipe
// against a behavioural Y86-64 execute/E-M register model.
module tb_exec_stage_pipe;
    localparam int W = 64;
    localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exec_stage_pipe_if #(.WIDTH(W)) io ();
    exec_stage_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io(io));

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]  r_cc;
    logic [2:0]  r_stat;
    logic [3:0]  r_icode;
    logic        r_cnd;
    logic [63:0] r_valE, r_valA;
    logic [3:0]  r_dstE, r_dstM;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_bubble_model();
        r_stat = 3'd1; r_icode = 4'h1; r_cnd = 1'b0;
        r_valE = '0; r_valA = '0; r_dstE = 4'hF; r_dstM = 4'hF;
    endtask

    task automatic set_in(input logic [2:0] st, input logic [3:0] ic,
                          input logic [3:0] fn, input logic [63:0] va,
                          input logic [63:0] vb, input logic [63:0] vc,
                          input logic [3:0] de, input logic [3:0] dm);
        io.e_stat = st; io.e_icode = ic; io.e_ifun = fn;
        io.e_valA = va; io.e_valB = vb; io.e_valC = vc;
        io.e_dstE_in = de; io.e_dstM = dm;
    endtask

    function automatic logic signed [65:0] sx(input logic [63:0] v);
        return $signed({{2{v[63]}}, v});
    endfunction

    // One cycle: check forwarding outputs mid-cycle, advance the model,
    // then check registered outputs just after the edge.
    task automatic step(input string tag);
        logic [63:0] ev;
        logic        ec, opok, we, lt, zf;
        logic [3:0]  ed;
        logic [2:0]  nf;
        logic signed [65:0] ws;
        #4;
        opok = (io.e_ifun <= 4'd3);
        ev = '0;
        nf = r_cc;
        case (io.e_icode)
            4'h3: ev = io.e_valC;
            4'h4, 4'h5: ev = io.e_valB + io.e_valC;
            4'h2: ev = io.e_valA;
            4'h8, 4'hA: ev = io.e_valB - 64'd8;
            4'h9, 4'hB: ev = io.e_valB + 64'd8;
            4'h6: begin
                case (io.e_ifun)
                    4'h0: begin
                        ev = io.e_valB + io.e_valA;
                        ws = sx(io.e_valB) + sx(io.e_valA);
                        nf = {ev == 0, $signed(ev) < 0, ws > SMAX || ws < SMIN};
                    end
                    4'h1: begin
                        ev = io.e_valB - io.e_valA;
                        ws = sx(io.e_valB) - sx(io.e_valA);
                        nf = {ev == 0, $signed(ev) < 0, ws > SMAX || ws < SMIN};
                    end
                    4'h2: begin
                        ev = io.e_valB & io.e_valA;
                        nf = {ev == 0, $signed(ev) < 0, 1'b0};
                    end
                    4'h3: begin
                        ev = io.e_valB ^ io.e_valA;
                        nf = {ev == 0, $signed(ev) < 0, 1'b0};
                    end
                    default: ev = '0;
                endcase
            end
            default: ev = '0;
        endcase
        lt = r_cc[1] ^ r_cc[0];
        zf = r_cc[2];
        ec = 1'b0;
        if (io.e_icode == 4'h2 || io.e_icode == 4'h7) begin
            case (io.e_ifun)
                4'h0: ec = 1'b1;
                4'h1: ec = lt || zf;
                4'h2: ec = lt;
                4'h3: ec = zf;
                4'h4: ec = !zf;
                4'h5: ec = !lt;
                4'h6: ec = !lt && !zf;
                default: ec = 1'b0;
            endcase
        end
        ed = (io.e_icode == 4'h2 && !ec) ? 4'hF : io.e_dstE_in;
        chk({tag, ".valE"}, io.e_valE, ev);
        chk({tag, ".cnd"}, 64'(io.e_cnd), 64'(ec));
        chk({tag, ".dstE"}, 64'(io.e_dstE), 64'(ed));
        we = io.e_icode == 4'h6 && opok && !io.set_cc_block &&
             io.e_stat == 3'd1 && !io.m_stall;
        if (rst) begin
            r_cc = 3'b100;
            m_bubble_model();
        end else begin
            if (we) r_cc = nf;
            if (io.m_stall) begin
            end else if (io.m_bubble) begin
                m_bubble_model();
            end else begin
                r_stat  = (io.e_icode == 4'h6 && !opok) ? 3'd4 : io.e_stat;
                r_icode = io.e_icode;
                r_cnd   = ec;
                r_valE  = ev;
                r_valA  = io.e_valA;
                r_dstE  = ed;
                r_dstM  = io.e_dstM;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".cc"}, 64'(io.cc_out), 64'(r_cc));
        chk({tag, ".Mstat"}, 64'(io.M_stat), 64'(r_stat));
        chk({tag, ".Micode"}, 64'(io.M_icode), 64'(r_icode));
        chk({tag, ".Mcnd"}, 64'(io.M_cnd), 64'(r_cnd));
        chk({tag, ".MvalE"}, io.M_valE, r_valE);
        chk({tag, ".MvalA"}, io.M_valA, r_valA);
        chk({tag, ".MdstE"}, 64'(io.M_dstE), 64'(r_dstE));
        chk({tag, ".MdstM"}, 64'(io.M_dstM), 64'(r_dstM));
        chk({tag, ".busy"}, 64'(io.busy), 64'd0);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0: return {$urandom(), $urandom()};
            1: return 64'($urandom_range(0, 15));
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return 64'h8000_0000_0000_0000;
        endcase
    endfunction

    initial begin
        logic [2:0] cc_prev;
        logic [3:0] ic, fn;
        int cyc;
        rst = 1'b1;
        io.set_cc_block = 1'b0; io.m_stall = 1'b0; io.m_bubble = 1'b0;
        set_in(3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        step("rst");
        chk("rst.cc_const", 64'(io.cc_out), 64'd4);
        chk("rst.icode_const", 64'(io.M_icode), 64'd1);
        rst = 1'b0;

        set_in(3'd1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h3, 4'hF);
        step("addov");
        chk("addov.valE_const", io.M_valE, 64'h8000_0000_0000_0000);
        chk("addov.cc_const", 64'(io.cc_out), 64'd3);

        set_in(3'd1, 4'h6, 4'h1, 64'd5, 64'd5, 0, 4'h3, 4'hF);
        step("sub55");
        chk("sub55.cc_const", 64'(io.cc_out), 64'd4);
        set_in(3'd1, 4'h2, 4'h1, 64'h1234, 0, 0, 4'h3, 4'hF);
        step("cmovle1");
        chk("cmovle1.dstE_const", 64'(io.M_dstE), 64'd3);
        set_in(3'd1, 4'h6, 4'h1, 64'd5, 64'd9, 0, 4'h3, 4'hF);
        step("sub95");
        set_in(3'd1, 4'h2, 4'h1, 64'h1234, 0, 0, 4'h3, 4'hF);
        step("cmovle0");
        chk("cmovle0.dstE_const", 64'(io.M_dstE), 64'hF);

        io.set_cc_block = 1'b1;
        set_in(3'd1, 4'h6, 4'h3, 64'd7, 64'd7, 0, 4'h1, 4'hF);
        step("ccblk");
        chk("ccblk.cc_const", 64'(io.cc_out), 64'd0);
        io.set_cc_block = 1'b0;

        set_in(3'd1, 4'hA, 4'h0, 64'd0, 64'h100, 0, 4'h4, 4'hF);
        step("push");
        chk("push.valE_const", io.M_valE, 64'hF8);
        set_in(3'd1, 4'hB, 4'h0, 64'd0, 64'h100, 0, 4'h4, 4'h2);
        step("pop");
        chk("pop.valE_const", io.M_valE, 64'h108);

        set_in(3'd1, 4'h3, 4'h0, 64'd0, 64'd0, 64'hABC, 4'h5, 4'hF);
        step("irmov");
        io.m_stall = 1'b1; io.m_bubble = 1'b1;
        set_in(3'd1, 4'h6, 4'h0, 64'd3, 64'd4, 0, 4'h6, 4'hF);
        step("stbub1");
        step("stbub2");
        chk("stbub.valE_const", io.M_valE, 64'hABC);
        io.m_stall = 1'b0;
        step("bubble");
        chk("bubble.icode_const", 64'(io.M_icode), 64'd1);
        chk("bubble.dstE_const", 64'(io.M_dstE), 64'hF);
        io.m_bubble = 1'b0;

`ifdef EXEC_MUL_EN
        set_in(3'd1, 4'h6, 4'h4, 64'd7, 64'd6, 0, 4'h2, 4'hF);
        @(posedge clk); #1;
        cyc = 0;
        while (io.busy === 1'b1 && cyc < 200) begin
            chk("mul.bubble", 64'(io.M_icode), 64'd1);
            cyc++;
            @(posedge clk); #1;
        end
        chk("mul.cycles", 64'(cyc), 64'(W));
        chk("mul.fwd", io.e_valE, 64'd42);
        @(posedge clk); #1;
        set_in(3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        chk("mul.MvalE", io.M_valE, 64'd42);
        chk("mul.cc", 64'(io.cc_out), 64'd0);
        r_cc = 3'b000; r_stat = 3'd1; r_icode = 4'h6; r_cnd = 1'b0;
        r_valE = 64'd42; r_valA = 64'd7; r_dstE = 4'h2; r_dstM = 4'hF;
        set_in(3'd1, 4'h6, 4'h4, 64'd7, 64'd6, 0, 4'h2, 4'hF);
        repeat (6) begin @(posedge clk); #1; end
        chk("mulrst.busy_run", 64'(io.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mulrst.busy", 64'(io.busy), 64'd0);
        rst = 1'b0;
        set_in(3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        r_cc = 3'b100;
        m_bubble_model();
`else
        cc_prev = io.cc_out;
        set_in(3'd1, 4'h6, 4'h4, 64'd7, 64'd6, 0, 4'h2, 4'hF);
        step("illegal");
        chk("illegal.stat_const", 64'(io.M_stat), 64'd4);
        chk("illegal.cc_hold", 64'(io.cc_out), 64'(cc_prev));
`endif

        for (int i = 0; i < 400; i++) begin
            ic = 4'($urandom_range(0, 11));
            fn = 4'h0;
            if (ic == 4'h6) fn = 4'($urandom_range(0, 5));
            if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 7));
`ifdef EXEC_MUL_EN
            if (ic == 4'h6 && fn == 4'h4) fn = 4'h5;
`endif
            set_in(($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1,
                   ic, fn, rnd64(), rnd64(), rnd64(),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            io.set_cc_block = ($urandom_range(0, 7) == 0);
            io.m_stall      = ($urandom_range(0, 7) == 0);
            io.m_bubble     = ($urandom_range(0, 7) == 0);
            rst             = ($urandom_range(0, 31) == 0);
            step("rand");
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/exec_stage_pipe.md
Name: exec_stage_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle SEQ execute block, for the PIPE Y86-64 core.
- Sits between the D/E pipeline register and the memory stage. Computes valE and cnd, and owns the architectural condition-code register.
- Drives the E/M pipeline register, with stall/bubble control from the hazard unit, and forwards e_valE/e_dstE to decode.

Parameters:
- WIDTH, 64: datapath width in bits for valA, valB, valC and valE.
- STACK_STEP, 8: byte adjustment applied to %rsp by call, ret, pushq and popq.
- RNONE, 4'hF: register ID meaning "no destination".

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- e_stat  in  3  stage status (1 AOK, 2 HLT, 3 ADR, 4 INS).
- e_icode, e_ifun  in  4 each  instruction code and function.
- e_valA, e_valB, e_valC  in  WIDTH each  operands.
- e_dstE_in, e_dstM  in  4 each  destination register IDs.
- set_cc_block  in  1  exception in M/W: suppresses CC update.
- m_stall  in  1  holds the E/M register.
- m_bubble  in  1  loads a nop into the E/M register.
- e_valE  out  WIDTH  combinational result, for forwarding.
- e_dstE  out  4  combinational effective dstE (RNONE when a cmov fails).
- e_cnd  out  1  combinational condition result.
- cc_out  out  3  registered {ZF, SF, OF}.
- busy  out  1  execute stage occupied. Always 0 unless MUL_EN.
- M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM  out  registered E/M pipeline fields.

Behaviour:
- Reset (rst high at a clk edge):
  - CC = 3'b100 (ZF set).
  - E/M register loads a bubble: M_stat=1, M_icode=1 (nop), M_cnd=0, M_valE=0, M_valA=0, M_dstE=RNONE, M_dstM=RNONE.
  - busy=0.
  - Reset overrides stall and bubble.
- valE per icode:
  - irmovq: valC.
  - rmmovq, mrmovq: valB+valC.
  - rrmovq/cmovXX: valA.
  - OPq: ifun 0 gives valB+valA, 1 gives valB-valA, 2 gives valB&valA, 3 gives valB^valA.
  - call, pushq: valB-STACK_STEP.
  - ret, popq: valB+STACK_STEP.
  - All others: 0.
- Arithmetic: wrap modulo 2^WIDTH.
- Flag rules for OPq:
  - ZF = (result==0); SF = result[WIDTH-1].
  - OF for add: operands share a sign and the result sign differs.
  - OF for sub: operand signs differ and the result sign differs from valB.
  - OF for and/xor: 0.
- OPq with ifun>3 (and ifun 4 when MUL_EN is off):
  - e_valE=0; the E/M register latches M_stat=4 (INS).
  - CC unchanged.
- CC register update:
  - Written at the clk edge only when icode==OPq, the ifun is valid, set_cc_block==0, e_stat==AOK, and the stage is not stalled.
  - Otherwise CC holds.
- Condition evaluation:
  - Uses the registered CC, i.e. flags from earlier OPqs, never the current one.
  - ifun 0 always; 1 le ((SF^OF)|ZF); 2 l (SF^OF); 3 e (ZF); 4 ne (~ZF); 5 ge (~(SF^OF)); 6 g (~(SF^OF)&~ZF); 7+ gives 0.
  - Applies to icode 2 and 7 only; e_cnd=0 for every other icode.
  - e_dstE = RNONE when icode==2 and e_cnd==0; otherwise e_dstE_in.
- E/M register at each clk edge, priority rst > m_stall > m_bubble > load:
  - m_stall: all M_* hold.
  - m_bubble: load the reset values.
  - Load: capture e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM.
  - m_stall and m_bubble together: stall wins.
- Latency: one cycle from E inputs to M_* outputs. Forwarding outputs are zero-latency.

Optional Feature:
- Macro: EXEC_MUL_EN.
- When defined, OPq ifun 4 (mulq) computes valB*valA, low WIDTH bits, with an iterative shift-add FSM.
  - States: IDLE, RUN, DONE.
  - IDLE to RUN when icode==6, ifun==4, e_stat==AOK: latch the operands, counter=0, busy=1.
  - RUN: one bit per cycle, WIDTH cycles.
  - DONE: e_valE = product, busy=0. The E/M register loads on this edge when not stalled.
  - While busy=1, the hazard unit holds D/E; the E/M register loads bubbles each cycle unless m_stall.
  - Flags: ZF/SF from the product, OF=0.
  - rst mid-RUN returns to IDLE with busy=0 and discards the product.
- When undefined: ifun 4 is INS as above; busy is tied to 0.

Test Plan:
- Add with overflow, rst then no stall: OPq addq, valB=0x7FFF_FFFF_FFFF_FFFF, valA=1 -> next cycle M_valE=0x8000_0000_0000_0000, cc_out=3'b011.
- Sub equal, then cmovle: subq valB=5, valA=5 -> CC=3'b100. Next cycle cmovle (2/1) valA=0x1234, e_dstE_in=3 -> e_cnd=1, M_dstE=3. Repeat after subq valB=9, valA=5 -> e_cnd=0, M_dstE=0xF.
- CC suppression: set_cc_block=1 during xorq 7^7 -> CC keeps its prior value 3'b000.
- Stack ops, STACK_STEP=8: pushq valB=0x100 -> M_valE=0xF8. popq valB=0x100 -> M_valE=0x108.
- Stall/bubble: m_stall=1 and m_bubble=1 together for 2 cycles -> M_* hold. m_bubble alone -> M_icode=1, M_dstE=0xF, M_stat=1.
- Illegal and mul: OPq ifun=4 valB=6, valA=7. Without EXEC_MUL_EN -> M_stat=4, CC unchanged. With EXEC_MUL_EN -> busy high WIDTH cycles, then M_valE=42, CC=3'b000. rst mid-RUN -> busy=0 next edge.
